// File: rtl/bram_port_arbiter.sv
`timescale 1ns/1ps
// bram_port_arbiter
// Shares the single port of BLOCK_MEM between the sample loader (write side)
// and the RLS core (read side). One access per cycle, burst-limited
// round-robin between the two, registered memory command, and a read-valid
// strobe aligned to the BRAM read latency.
//
// Build option: define BRAM_ARB_WR_PRIORITY_EN to give the write requester
// fixed priority (used while the memory is first being filled). Without it
// the arbiter runs burst-limited round-robin.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 98304,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OWN = 2'd1,
        RD_OWN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_rd_reg, last_rd_next;   // 1: last owner was the read side
    logic             grant_wr, grant_rd;
    logic             wr_oor, rd_oor;
    logic             rd_cmd_reg;
    logic [RD_LATENCY-1:0] rd_pipe_reg, rd_pipe_next;

    assign wr_oor = (wr_addr >= ADDR_LIMIT);
    assign rd_oor = (rd_addr >= ADDR_LIMIT);

    // Grant selection from current ownership, burst count and requests
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
`ifdef BRAM_ARB_WR_PRIORITY_EN
        grant_wr = wr_req;
        grant_rd = rd_req & ~wr_req;
`else
        case (state_reg)
            WR_OWN: begin
                if (wr_req && (!rd_req || (cnt_reg < CNT_MAX))) grant_wr = 1'b1;
                else if (rd_req)                                 grant_rd = 1'b1;
            end
            RD_OWN: begin
                if (rd_req && (!wr_req || (cnt_reg < CNT_MAX))) grant_rd = 1'b1;
                else if (wr_req)                                 grant_wr = 1'b1;
            end
            default: begin
                if (wr_req && rd_req) begin
                    grant_wr = last_rd_reg;
                    grant_rd = ~last_rd_reg;
                end else begin
                    grant_wr = wr_req;
                    grant_rd = rd_req;
                end
            end
        endcase
`endif
    end

    // Nothing is handed out while reset is held, so no request is consumed then
    assign wr_gnt = grant_wr & rst_n;
    assign rd_gnt = grant_rd & rst_n;

    // Next ownership state and burst count follow whichever side was granted
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_rd_next = last_rd_reg;
        if (grant_wr) begin
            state_next = WR_OWN;
            if (state_reg == WR_OWN) cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
            else                     cnt_next = CNT_ONE;
        end else if (grant_rd) begin
            state_next = RD_OWN;
            if (state_reg == RD_OWN) cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
            else                     cnt_next = CNT_ONE;
        end else begin
            state_next = IDLE;
            if (state_reg == WR_OWN)      last_rd_next = 1'b0;
            else if (state_reg == RD_OWN) last_rd_next = 1'b1;
        end
    end

    // Arbitration state register; last owner starts as read so write wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            last_rd_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_rd_reg <= last_rd_next;
        end
    end

    // Registered memory command; out-of-range grants are dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rd_cmd_reg <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            mem_we     <= grant_wr & ~wr_oor;
            rd_cmd_reg <= grant_rd & ~rd_oor;
            addr_err   <= (grant_wr & wr_oor) | (grant_rd & rd_oor);
            if (grant_wr && !wr_oor) begin
                mem_addr <= wr_addr;
                mem_din  <= wr_data;
            end else if (grant_rd && !rd_oor) begin
                mem_addr <= rd_addr;
            end
        end
    end

    // Read-valid delay line: one stage per cycle of BRAM read latency
    assign rd_pipe_next[0] = rd_cmd_reg;
    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            assign rd_pipe_next[gi] = rd_pipe_reg[gi-1];
        end
    endgenerate

    // Shift the read-valid line; reset drops any reads still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe_reg <= '0;
        else        rd_pipe_reg <= rd_pipe_next;
    end

    assign rd_valid = rd_pipe_reg[RD_LATENCY-1];
    assign rd_data  = rd_valid ? mem_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
`timescale 1ns/1ps
// Testbench for bram_port_arbiter: reset values, write/read-back table,
// contention pattern, out-of-range handling and reset during a read.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req, rd_req;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic        wr_gnt, rd_gnt, rd_valid, addr_err, mem_we;
    logic [31:0] rd_data, mem_addr, mem_din, mem_dout;

    int n_checks = 0;
    int n_fail   = 0;

    bram_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Small write-first BRAM model with two cycles of read latency
    logic [31:0] bram [256];
    logic [31:0] dout_s1;
    always_ff @(posedge clk) begin
        if (mem_we) bram[mem_addr[7:0]] <= mem_din;
        dout_s1  <= mem_we ? mem_din : bram[mem_addr[7:0]];
        mem_dout <= dout_s1;
    end

    typedef struct {
        logic        wr_req;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        rd_req;
        logic [31:0] rd_addr;
        logic        e_wr_gnt;
        logic        e_rd_gnt;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_rd_valid;
        logic [31:0] e_rd_data;
        logic        e_addr_err;
    } vec_t;

    vec_t vt[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " flags"}, {27'd0, wr_gnt, rd_gnt, rd_valid, addr_err, mem_we}, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_din"}, mem_din, 32'd0);
        check({tag, " rd_data"}, rd_data, 32'd0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rdg, n_rdv, n_err, exp_rdg;
        logic exp_w;

        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Write 0..9 with data = address, read them back, then drain
        for (int k = 0; k < 23; k++) begin
            vt[k] = '{default: '0};
            if (k < 10) begin
                vt[k].wr_req = 1'b1; vt[k].wr_addr = 32'(k); vt[k].wr_data = 32'(k);
                vt[k].e_wr_gnt = 1'b1;
            end else if (k < 20) begin
                vt[k].rd_req = 1'b1; vt[k].rd_addr = 32'(k - 10);
                vt[k].e_rd_gnt = 1'b1;
            end
            vt[k].e_mem_we   = (k >= 1 && k <= 10);
            vt[k].e_mem_addr = (k == 0) ? 32'd0 : (k <= 10) ? 32'(k - 1) :
                               (k <= 20) ? 32'(k - 11) : 32'd9;
            vt[k].e_rd_valid = (k >= 13);
            vt[k].e_rd_data  = (k >= 13) ? 32'(k - 13) : 32'd0;
        end

        // ---- Reset values during and after reset
        repeat (3) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        // ---- Table: write then read back
        for (int k = 0; k < 23; k++) begin
            @(posedge clk); #1;
            wr_req = vt[k].wr_req; wr_addr = vt[k].wr_addr; wr_data = vt[k].wr_data;
            rd_req = vt[k].rd_req; rd_addr = vt[k].rd_addr;
            @(negedge clk);
            $display("vec %0d: wr_gnt=%0b rd_gnt=%0b mem_we=%0b mem_addr=%0d rd_valid=%0b rd_data=%0d",
                     k, wr_gnt, rd_gnt, mem_we, mem_addr, rd_valid, rd_data);
            check($sformatf("tbl[%0d] wr_gnt", k), {31'd0, wr_gnt}, {31'd0, vt[k].e_wr_gnt});
            check($sformatf("tbl[%0d] rd_gnt", k), {31'd0, rd_gnt}, {31'd0, vt[k].e_rd_gnt});
            check($sformatf("tbl[%0d] mem_we", k), {31'd0, mem_we}, {31'd0, vt[k].e_mem_we});
            check($sformatf("tbl[%0d] mem_addr", k), mem_addr, vt[k].e_mem_addr);
            if (vt[k].e_mem_we)
                check($sformatf("tbl[%0d] mem_din", k), mem_din, vt[k].e_mem_addr);
            check($sformatf("tbl[%0d] rd_valid", k), {31'd0, rd_valid}, {31'd0, vt[k].e_rd_valid});
            check($sformatf("tbl[%0d] rd_data", k), rd_data, vt[k].e_rd_data);
            check($sformatf("tbl[%0d] addr_err", k), {31'd0, addr_err}, {31'd0, vt[k].e_addr_err});
        end

        // ---- Contention: both requests held from reset
        rst_n = 1'b0;
        wr_req = 1'b1; wr_addr = 32'd100; wr_data = 32'h100;
        rd_req = 1'b1; rd_addr = 32'd200;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_rdg = 0; n_rdv = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
`ifdef BRAM_ARB_WR_PRIORITY_EN
            exp_w = 1'b1;
`else
            exp_w = (i < 16) || (i >= 32);
`endif
            $display("cont %0d: wr_gnt=%0b rd_gnt=%0b", i, wr_gnt, rd_gnt);
            check($sformatf("cont[%0d] gnts", i), {30'd0, wr_gnt, rd_gnt}, {30'd0, exp_w, ~exp_w});
            n_rdg += int'(rd_gnt);
            n_rdv += int'(rd_valid);
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        @(negedge clk);
        check("cont wr_drop rd_gnt", {31'd0, rd_gnt}, 32'd1);
        n_rdg += int'(rd_gnt);
        n_rdv += int'(rd_valid);
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_rdv += int'(rd_valid);
        end
`ifdef BRAM_ARB_WR_PRIORITY_EN
        exp_rdg = 1;
`else
        exp_rdg = 17;
`endif
        check("cont rd_gnt count", 32'(n_rdg), 32'(exp_rdg));
        check("cont rd_valid count", 32'(n_rdv), 32'(exp_rdg));

        // ---- Out-of-range accesses
        do_reset();
        n_err = 0;
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 32'd98304; wr_data = 32'hDEAD;
        @(negedge clk);
        $display("oor wr: wr_gnt=%0b", wr_gnt);
        check("oor wr_gnt", {31'd0, wr_gnt}, 32'd1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            wr_req = 1'b0;
            rd_req = (c == 3) || (c == 8);
            rd_addr = (c == 3) ? 32'd98303 : 32'd98304;
            @(negedge clk);
            $display("oor %0d: mem_we=%0b addr_err=%0b rd_gnt=%0b rd_valid=%0b",
                     c, mem_we, addr_err, rd_gnt, rd_valid);
            n_err += int'(addr_err);
            check($sformatf("oor[%0d] mem_we", c), {31'd0, mem_we}, 32'd0);
            check($sformatf("oor[%0d] addr_err", c), {31'd0, addr_err}, {31'd0, (c == 1) || (c == 9)});
            check($sformatf("oor[%0d] rd_gnt", c), {31'd0, rd_gnt}, {31'd0, (c == 3) || (c == 8)});
            check($sformatf("oor[%0d] rd_valid", c), {31'd0, rd_valid}, {31'd0, c == 6});
            if (c == 4) check("oor rd mem_addr", mem_addr, 32'd98303);
        end
        check("oor addr_err pulses", 32'(n_err), 32'd2);

        // ---- Reset asserted while a read is in flight
        do_reset();
        @(posedge clk); #1 rd_req = 1'b1; rd_addr = 32'd5;
        @(negedge clk);
        check("midrst rd_gnt", {31'd0, rd_gnt}, 32'd1);
        @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b1; wr_addr = 32'd6; wr_data = 32'h66;
        @(negedge clk);
        check("midrst wr_gnt", {31'd0, wr_gnt}, 32'd1);
        @(posedge clk); #1 wr_req = 1'b0;
        check("midrst mem_we before reset", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        $display("midrst: reset asserted, mem_we=%0b rd_valid=%0b", mem_we, rd_valid);
        check_idle("midrst async");
        @(negedge clk);
        check_idle("midrst held");
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst held2");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("midrst after[%0d] rd_valid/mem_we", i), {30'd0, rd_valid, mem_we}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single port of BLOCK_MEM (32-bit data, 98304 words) between two requesters.
- Write requester: the sample loader that fills memory.
- Read requester: the RLS core fetching samples/coefficients.
- Grants one access per cycle with burst-limited round-robin, registers the memory command, and returns read data with a valid strobe aligned to the BRAM read latency.

Parameters:
- ADDR_W, 32, address width of both requesters and of mem_addr.
- DATA_W, 32, data width.
- DEPTH, 98304, number of valid words; addresses >= DEPTH are out of range.
- RD_LATENCY, 2, cycles from mem_addr presented (mem_we=0) to mem_dout valid; legal range 1..4.
- MAX_BURST, 16, maximum consecutive grants to one owner while the other requester is waiting.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request; held until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request; held until rd_gnt.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_data  out  DATA_W  returned read data.
- rd_valid  out  1  rd_data valid this cycle.
- addr_err  out  1  one-cycle pulse: granted access had address >= DEPTH.
- mem_we  out  1  to BLOCK_MEM wea.
- mem_addr  out  ADDR_W  to BLOCK_MEM addra.
- mem_din  out  DATA_W  to BLOCK_MEM dina.
- mem_dout  in  DATA_W  from BLOCK_MEM douta.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - wr_gnt=0, rd_gnt=0, rd_valid=0, addr_err=0.
  - mem_we=0, mem_addr=0, mem_din=0, rd_data=0.
  - State IDLE, burst count 0, last owner = RD, so WR wins the first tie.
- Grant generation:
  - wr_gnt and rd_gnt are combinational from state and requests.
  - At most one is high per cycle.
  - A request is consumed on the cycle its grant is high.
- Memory command:
  - Registered on the rising edge ending the grant cycle.
  - mem_we=1 for a write grant, 0 otherwise.
  - mem_addr and mem_din take the granted address and data.
  - With no grant: mem_we=0 and mem_addr/mem_din hold their previous values.
- States:
  - IDLE:
    - Only one requester active → grant it; go to WR_OWN or RD_OWN; burst count := 1.
    - Both active → grant the one not equal to the last owner.
    - None active → stay.
  - WR_OWN / RD_OWN:
    - Owner requesting and (other idle or count < MAX_BURST) → grant owner; count := count+1, saturating at MAX_BURST.
    - Owner requesting, other waiting, count == MAX_BURST → grant the other; switch state; count := 1.
    - Owner not requesting, other requesting → grant the other; switch state; count := 1.
    - Neither requesting → IDLE; last owner := current owner.
- Read return:
  - A RD_LATENCY-deep valid shift register is loaded with 1 when a read command is registered.
  - rd_valid=1 and rd_data=mem_dout exactly RD_LATENCY cycles after mem_addr presents the read address.
  - Back-to-back reads give back-to-back rd_valid in issue order.
- Out-of-range address (>= DEPTH):
  - Grant is still given, so the requester is not stalled.
  - The memory command is suppressed: mem_we forced 0, no read-valid issued.
  - addr_err pulses on the cycle after the grant.
- Write followed by read to the same address on the next grant returns the new data (BRAM write-first); no extra hazard logic.
- Reset asserted mid-operation:
  - All outputs are forced to reset values immediately.
  - In-flight read-valid bits are cleared, so no rd_valid follows reset.
- Burst count width: clog2(MAX_BURST)+1.

Optional Feature:
- Macro: BRAM_ARB_WR_PRIORITY_EN.
- Defined: fixed priority.
  - wr_req always wins when both request; MAX_BURST and round-robin are ignored.
  - Read is granted only when wr_req=0.
  - Used during initial memory fill.
- Undefined: burst-limited round-robin as above.

Test Plan:
- Reset check: rst_n low for 3 cycles, then high with no requests → every output at reset value; mem_we=0 for 10 cycles.
- Write then read back:
  - wr_req held for addresses 0..9, data = address → 10 consecutive wr_gnt; mem_we=1 on each; mem_addr 0..9.
  - Then rd_req for addresses 0..9 → rd_valid for 10 cycles with rd_data 0..9, first rd_valid 3 cycles after first rd_gnt.
- Contention, default build:
  - wr_req and rd_req both held continuously from reset → grants go WR×16, RD×16, WR×16.
  - rd_valid count equals rd_gnt count.
- Out of range:
  - Write 98304 → wr_gnt=1, mem_we stays 0, addr_err pulses once.
  - Read 98303 → normal rd_valid.
- Reset mid-burst: rst_n low 1 cycle after a rd_gnt → no rd_valid afterwards; mem_we=0 during reset.
- BRAM_ARB_WR_PRIORITY_EN defined:
  - Both requests held 40 cycles → 40 wr_gnt, 0 rd_gnt.
  - wr_req dropped → rd_gnt the same cycle.
